// File: rtl/dcache_responder.sv
// Direct-mapped, write-back, write-allocate data cache answering the memory
// stage on the *_b bus; misses go out over a 128-bit physical-memory port.
//
// state     | meaning
// IDLE      | serve hits; detect misses and latch the miss address
// WRITEBACK | push the dirty victim line to physical memory
// ALLOCATE  | fetch the requested line from physical memory
module dcache_responder #(
    parameter int INDEX_BITS = 3,
    parameter int LINE_BITS  = 128
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 mem_read_b,
    input  logic                 mem_write_b,
    input  logic [15:0]          mem_address_b,
    input  logic [15:0]          mem_wdata_b,
    input  logic [1:0]           mem_wmask_b,
    output logic                 mem_resp_b,
    output logic [15:0]          mem_rdata_b,
    output logic                 pmem_read,
    output logic                 pmem_write,
    output logic [15:0]          pmem_address,
    output logic [LINE_BITS-1:0] pmem_wdata,
    input  logic [LINE_BITS-1:0] pmem_rdata,
    input  logic                 pmem_resp
);

    localparam int LINES    = 1 << INDEX_BITS;
    localparam int TAG_BITS = 12 - INDEX_BITS;

    typedef enum logic [1:0] {IDLE, WRITEBACK, ALLOCATE} state_t;

    state_t state, state_next;

    logic [LINES-1:0]     valid;
    logic [LINES-1:0]     dirty;
    logic [TAG_BITS-1:0]  tag_arr  [LINES];
    logic [LINE_BITS-1:0] data_arr [LINES];

    logic [TAG_BITS-1:0]   req_tag;
    logic [INDEX_BITS-1:0] req_index;
    logic [2:0]            req_word;
    logic [6:0]            lo_bit;
    logic [6:0]            hi_bit;
    logic                  request;
    logic                  hit;

    // Miss address captured when leaving IDLE so later input changes cannot
    // disturb an in-flight writeback or fill.
    logic [TAG_BITS-1:0]   miss_tag;
    logic [TAG_BITS-1:0]   victim_tag;
    logic [INDEX_BITS-1:0] miss_index;

    // Byte offset bit 0 is meaningless for a 16-bit word access.
    logic unused_addr_bit;
    assign unused_addr_bit = mem_address_b[0];

    assign req_tag   = mem_address_b[15:4+INDEX_BITS];
    assign req_index = mem_address_b[3+INDEX_BITS:4];
    assign req_word  = mem_address_b[3:1];
    assign lo_bit    = {req_word, 4'h0};
    assign hi_bit    = {req_word, 4'h8};
    assign request   = mem_read_b ^ mem_write_b;
    assign hit       = request && valid[req_index] && (tag_arr[req_index] == req_tag);

    // Next-state decode and all bus outputs.
    always_comb begin
        state_next   = state;
        mem_resp_b   = 1'b0;
        mem_rdata_b  = 16'h0000;
        pmem_read    = 1'b0;
        pmem_write   = 1'b0;
        pmem_address = 16'h0000;
        pmem_wdata   = '0;
        case (state)
            IDLE: begin
                if (hit) begin
                    mem_resp_b = 1'b1;
                    if (mem_read_b) begin
                        mem_rdata_b = data_arr[req_index][lo_bit +: 16];
                    end
                end else if (request) begin
                    if (valid[req_index] && dirty[req_index]) begin
                        state_next = WRITEBACK;
                    end else begin
                        state_next = ALLOCATE;
                    end
                end
            end
            WRITEBACK: begin
                pmem_write   = 1'b1;
                pmem_address = {victim_tag, miss_index, 4'h0};
                pmem_wdata   = data_arr[miss_index];
                if (pmem_resp) begin
                    state_next = ALLOCATE;
                end
            end
            ALLOCATE: begin
                pmem_read    = 1'b1;
                pmem_address = {miss_tag, miss_index, 4'h0};
                if (pmem_resp) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // State register, line status bits and the latched miss address.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            valid      <= '0;
            dirty      <= '0;
            miss_tag   <= '0;
            victim_tag <= '0;
            miss_index <= '0;
        end else begin
            state <= state_next;
            if (state == IDLE && request && !hit) begin
                miss_tag   <= req_tag;
                victim_tag <= tag_arr[req_index];
                miss_index <= req_index;
            end
            if (state == IDLE && hit && mem_write_b) begin
                dirty[req_index] <= 1'b1;
            end
            if (state == WRITEBACK && pmem_resp) begin
                dirty[miss_index] <= 1'b0;
            end
            if (state == ALLOCATE && pmem_resp) begin
                valid[miss_index] <= 1'b1;
                dirty[miss_index] <= 1'b0;
            end
        end
    end

    // Tag and data arrays; never cleared, only valid bits gate their use.
    always_ff @(posedge clk) begin
        if (!reset) begin
            if (state == IDLE && hit && mem_write_b) begin
                if (mem_wmask_b[0]) begin
                    data_arr[req_index][lo_bit +: 8] <= mem_wdata_b[7:0];
                end
                if (mem_wmask_b[1]) begin
                    data_arr[req_index][hi_bit +: 8] <= mem_wdata_b[15:8];
                end
            end
            if (state == ALLOCATE && pmem_resp) begin
                data_arr[miss_index] <= pmem_rdata;
                tag_arr[miss_index]  <= miss_tag;
            end
        end
    end

endmodule

// File: tb/tb_dcache_responder.sv
// Directed bench for dcache_responder: stimulus pushes expected responses and
// physical-memory operations into queues; a monitor pops and compares.
module tb_dcache_responder;

    logic         clk = 1'b0;
    logic         reset;
    logic         mem_read_b;
    logic         mem_write_b;
    logic [15:0]  mem_address_b;
    logic [15:0]  mem_wdata_b;
    logic [1:0]   mem_wmask_b;
    logic         mem_resp_b;
    logic [15:0]  mem_rdata_b;
    logic         pmem_read;
    logic         pmem_write;
    logic [15:0]  pmem_address;
    logic [127:0] pmem_wdata;
    logic [127:0] pmem_rdata;
    logic         pmem_resp;

    dcache_responder #(.INDEX_BITS(3), .LINE_BITS(128)) dut (
        .clk           (clk),
        .reset         (reset),
        .mem_read_b    (mem_read_b),
        .mem_write_b   (mem_write_b),
        .mem_address_b (mem_address_b),
        .mem_wdata_b   (mem_wdata_b),
        .mem_wmask_b   (mem_wmask_b),
        .mem_resp_b    (mem_resp_b),
        .mem_rdata_b   (mem_rdata_b),
        .pmem_read     (pmem_read),
        .pmem_write    (pmem_write),
        .pmem_address  (pmem_address),
        .pmem_wdata    (pmem_wdata),
        .pmem_rdata    (pmem_rdata),
        .pmem_resp     (pmem_resp)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        is_read;
        logic [15:0] rdata;
    } resp_exp_t;

    typedef struct {
        logic        is_wr;
        logic [15:0] addr;
        logic        chk;
        logic [2:0]  w;
        logic [15:0] wval;
    } pm_exp_t;

    resp_exp_t    resp_q[$];
    pm_exp_t      pm_q[$];
    logic [127:0] store [logic [15:0]];
    logic         stray_req = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic push_rd(input logic [15:0] d);
        resp_exp_t e;
        e.is_read = 1'b1;
        e.rdata   = d;
        resp_q.push_back(e);
    endtask

    task automatic push_wr();
        resp_exp_t e;
        e.is_read = 1'b0;
        e.rdata   = 16'h0000;
        resp_q.push_back(e);
    endtask

    task automatic push_pm(input logic wr, input logic [15:0] a, input logic chk,
                           input logic [2:0] w, input logic [15:0] v);
        pm_exp_t p;
        p.is_wr = wr;
        p.addr  = a;
        p.chk   = chk;
        p.w     = w;
        p.wval  = v;
        pm_q.push_back(p);
    endtask

    // Issue one request and hold it until the response; lat counts the
    // sampled cycles from issue up to and including the response cycle.
    task automatic do_req(input logic rd, input logic [15:0] addr, input logic [15:0] wdata,
                          input logic [1:0] mask, output int lat);
        @(posedge clk);
        #1;
        mem_read_b    = rd;
        mem_write_b   = ~rd;
        mem_address_b = addr;
        mem_wdata_b   = wdata;
        mem_wmask_b   = mask;
        lat = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            lat++;
            if (mem_resp_b) break;
        end
        if (!mem_resp_b) check("req_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1;
        mem_read_b  = 1'b0;
        mem_write_b = 1'b0;
    endtask

    // Physical memory: 3-cycle latency; writes are stored, unwritten lines
    // read back as their own address replicated in every word.
    initial begin
        int cnt;
        cnt        = 0;
        pmem_resp  = 1'b0;
        pmem_rdata = '0;
        forever begin
            @(negedge clk);
            pmem_resp = 1'b0;
            if (pmem_read || pmem_write) begin
                cnt++;
                if (cnt == 3) begin
                    cnt       = 0;
                    pmem_resp = 1'b1;
                    if (pmem_write) begin
                        store[pmem_address] = pmem_wdata;
                    end else if (store.exists(pmem_address)) begin
                        pmem_rdata = store[pmem_address];
                    end else begin
                        pmem_rdata = {8{pmem_address}};
                    end
                end
            end else begin
                cnt = 0;
                if (stray_req) begin
                    pmem_resp = 1'b1;
                    stray_req = 1'b0;
                end
            end
        end
    end

    // Monitor: compares each response and each new physical-memory operation
    // against the head of its expectation queue.
    initial begin
        resp_exp_t  e;
        pm_exp_t    p;
        logic [1:0] prev_op;
        logic [1:0] op;
        prev_op = 2'b00;
        forever begin
            @(negedge clk);
            if (mem_resp_b === 1'b1) begin
                if (resp_q.size() == 0) begin
                    check("unexpected_resp", 32'd1, 32'd0);
                end else begin
                    e = resp_q.pop_front();
                    if (e.is_read) check("rdata", {16'h0, mem_rdata_b}, {16'h0, e.rdata});
                end
            end
            op = {pmem_read, pmem_write};
            if (op !== 2'b00 && op !== prev_op) begin
                check("pm_exclusive", {31'h0, pmem_read & pmem_write}, 32'd0);
                if (pm_q.size() == 0) begin
                    check("unexpected_pmem", {30'h0, op}, 32'd0);
                end else begin
                    p = pm_q.pop_front();
                    check("pm_op_write", {31'h0, pmem_write}, {31'h0, p.is_wr});
                    check("pm_addr", {16'h0, pmem_address}, {16'h0, p.addr});
                    if (p.chk) begin
                        check("pm_wdata_word", {16'h0, pmem_wdata[int'(p.w)*16 +: 16]}, {16'h0, p.wval});
                    end
                end
            end
            prev_op = op;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        reset         = 1'b1;
        mem_read_b    = 1'b0;
        mem_write_b   = 1'b0;
        mem_address_b = 16'h0000;
        mem_wdata_b   = 16'h0000;
        mem_wmask_b   = 2'b00;
        store[16'h0040] = 128'h0F0E_0D0C_0B0A_0908_0706_0504_0302_0100;
        repeat (2) @(negedge clk);
        check("rst_resp", {31'h0, mem_resp_b}, 32'd0);
        check("rst_pmem_read", {31'h0, pmem_read}, 32'd0);
        check("rst_pmem_write", {31'h0, pmem_write}, 32'd0);
        check("rst_pmem_addr", {16'h0, pmem_address}, 32'd0);
        check("rst_rdata", {16'h0, mem_rdata_b}, 32'd0);
        @(posedge clk);
        #1 reset = 1'b0;

        // 1: cold read miss, fill from 0x0040
        push_pm(1'b0, 16'h0040, 1'b0, 3'd0, 16'h0);
        push_rd(16'h0302);
        do_req(1'b1, 16'h0042, 16'h0, 2'b00, lat);
        check("t1_latency", lat, 5);

        // 2: byte write hit, read back; zero-mask write hit leaves data alone
        push_wr();
        do_req(1'b0, 16'h0046, 16'hAB00, 2'b10, lat);
        check("t2_write_latency", lat, 1);
        push_rd(16'hAB06);
        do_req(1'b1, 16'h0046, 16'h0, 2'b00, lat);
        check("t2_read_latency", lat, 1);
        push_wr();
        do_req(1'b0, 16'h0044, 16'hFFFF, 2'b00, lat);
        push_rd(16'h0504);
        do_req(1'b1, 16'h0044, 16'h0, 2'b00, lat);

        // 3: conflict miss on a dirty line: writeback then fill
        push_pm(1'b1, 16'h0040, 1'b1, 3'd3, 16'hAB06);
        push_pm(1'b0, 16'h0840, 1'b0, 3'd0, 16'h0);
        push_rd(16'h0840);
        do_req(1'b1, 16'h0840, 16'h0, 2'b00, lat);
        check("t3_latency", lat, 8);

        // 4: read and write together is no request; stray pmem_resp in IDLE
        @(posedge clk);
        #1;
        mem_read_b    = 1'b1;
        mem_write_b   = 1'b1;
        mem_address_b = 16'h0040;
        repeat (5) @(negedge clk);
        #1;
        mem_read_b  = 1'b0;
        mem_write_b = 1'b0;
        stray_req   = 1'b1;
        repeat (3) @(negedge clk);
        push_rd(16'h0840);
        do_req(1'b1, 16'h0840, 16'h0, 2'b00, lat);
        check("t4_still_hit_latency", lat, 1);

        // 5: reset during ALLOCATE aborts the fill; re-read refills
        push_pm(1'b0, 16'h0140, 1'b0, 3'd0, 16'h0);
        @(posedge clk);
        #1;
        mem_read_b    = 1'b1;
        mem_address_b = 16'h0140;
        repeat (2) @(negedge clk);
        check("t5_in_allocate", {31'h0, pmem_read}, 32'd1);
        @(posedge clk);
        #1;
        reset      = 1'b1;
        mem_read_b = 1'b0;
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("t5_pmem_read_after_rst", {31'h0, pmem_read}, 32'd0);
        check("t5_pmem_write_after_rst", {31'h0, pmem_write}, 32'd0);
        check("t5_pmem_addr_after_rst", {16'h0, pmem_address}, 32'd0);
        push_pm(1'b0, 16'h0140, 1'b0, 3'd0, 16'h0);
        push_rd(16'h0140);
        do_req(1'b1, 16'h0140, 16'h0, 2'b00, lat);
        check("t5_refill_latency", lat, 5);

        // 6: write miss allocates then writes; later conflict writes it back
        push_pm(1'b0, 16'h0100, 1'b0, 3'd0, 16'h0);
        push_wr();
        do_req(1'b0, 16'h0100, 16'h1234, 2'b11, lat);
        check("t6_write_miss_latency", lat, 5);
        push_pm(1'b1, 16'h0100, 1'b1, 3'd0, 16'h1234);
        push_pm(1'b0, 16'h0900, 1'b0, 3'd0, 16'h0);
        push_rd(16'h0900);
        do_req(1'b1, 16'h0900, 16'h0, 2'b00, lat);
        check("t6_conflict_latency", lat, 8);
        push_pm(1'b0, 16'h0100, 1'b0, 3'd0, 16'h0);
        push_rd(16'h1234);
        do_req(1'b1, 16'h0100, 16'h0, 2'b00, lat);
        check("t6_refetch_latency", lat, 5);

        repeat (3) @(negedge clk);
        check("resp_queue_drained", resp_q.size(), 32'd0);
        check("pmem_queue_drained", pm_q.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
